// File: rtl/alu_pkg.sv
// ALU operation codes shared by the ALU-control decoder and the execute stage.
// Extended codes exist only when ALU_EXT_OPS_EN is defined.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;

`ifdef ALU_EXT_OPS_EN
    localparam alu_op_t ALU_XOR  = 4'b0011;
    localparam alu_op_t ALU_SLTU = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
`endif

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: op code and operands to result and zero flag.
// ALU_EXT_OPS_EN adds XOR/SLTU/shifts; otherwise those codes compute ADD.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t           alu_control_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   result_c_o,
    output logic              zero_c_o
);

`ifdef ALU_EXT_OPS_EN
    localparam int unsigned SHW = $clog2(XLEN);
    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];
`endif

    logic slt_c;
    assign slt_c = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_c_o = a_i + b_i;
        case (alu_control_i)
            ALU_AND:  result_c_o = a_i & b_i;
            ALU_OR:   result_c_o = a_i | b_i;
            ALU_ADD:  result_c_o = a_i + b_i;
            ALU_SUB:  result_c_o = a_i + ~b_i + XLEN'(1);
            ALU_SLT:  result_c_o = {{(XLEN-1){1'b0}}, slt_c};
`ifdef ALU_EXT_OPS_EN
            ALU_XOR:  result_c_o = a_i ^ b_i;
            ALU_SLTU: result_c_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_SLL:  result_c_o = a_i << shamt;
            ALU_SRL:  result_c_o = a_i >> shamt;
            ALU_SRA:  result_c_o = XLEN'($signed(a_i) >>> shamt);
`endif
            default:  result_c_o = a_i + b_i;
        endcase
    end

    assign zero_c_o = (result_c_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with output register plus one-entry skid buffer.
// Optional ALU_EXT_OPS_EN enables extended op codes in alu_core.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           alu_control,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic [TAG_W-1:0]  tag_out
);

    logic [XLEN-1:0]  alu_result_c;
    logic             alu_zero_c;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .alu_control_i (alu_control),
        .a_i           (src_a),
        .b_i           (src_b),
        .result_c_o    (alu_result_c),
        .zero_c_o      (alu_zero_c)
    );

    logic             or_valid_q, or_valid_d;
    logic [XLEN-1:0]  or_result_q, or_result_d;
    logic             or_zero_q, or_zero_d;
    logic [TAG_W-1:0] or_tag_q, or_tag_d;
    logic             sk_valid_q, sk_valid_d;
    logic [XLEN-1:0]  sk_result_q, sk_result_d;
    logic             sk_zero_q, sk_zero_d;
    logic [TAG_W-1:0] sk_tag_q, sk_tag_d;

    logic accept_c;
    logic drain_c;

    assign accept_c = in_valid && !sk_valid_q;
    assign drain_c  = or_valid_q && out_ready;

    // OR refills from SK first to keep FIFO order; new ops go to SK only when OR is stuck
    always_comb begin
        or_valid_d  = or_valid_q;
        or_result_d = or_result_q;
        or_zero_d   = or_zero_q;
        or_tag_d    = or_tag_q;
        sk_valid_d  = sk_valid_q;
        sk_result_d = sk_result_q;
        sk_zero_d   = sk_zero_q;
        sk_tag_d    = sk_tag_q;
        if (!or_valid_q || drain_c) begin
            if (sk_valid_q) begin
                or_valid_d  = 1'b1;
                or_result_d = sk_result_q;
                or_zero_d   = sk_zero_q;
                or_tag_d    = sk_tag_q;
                sk_valid_d  = 1'b0;
            end else if (accept_c) begin
                or_valid_d  = 1'b1;
                or_result_d = alu_result_c;
                or_zero_d   = alu_zero_c;
                or_tag_d    = tag_in;
            end else begin
                or_valid_d  = 1'b0;
            end
        end else if (accept_c) begin
            sk_valid_d  = 1'b1;
            sk_result_d = alu_result_c;
            sk_zero_d   = alu_zero_c;
            sk_tag_d    = tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid_q  <= 1'b0;
            or_result_q <= '0;
            or_zero_q   <= 1'b0;
            or_tag_q    <= '0;
            sk_valid_q  <= 1'b0;
            sk_result_q <= '0;
            sk_zero_q   <= 1'b0;
            sk_tag_q    <= '0;
        end else begin
            or_valid_q  <= or_valid_d;
            or_result_q <= or_result_d;
            or_zero_q   <= or_zero_d;
            or_tag_q    <= or_tag_d;
            sk_valid_q  <= sk_valid_d;
            sk_result_q <= sk_result_d;
            sk_zero_q   <= sk_zero_d;
            sk_tag_q    <= sk_tag_d;
        end
    end

    assign in_ready  = !sk_valid_q;
    assign out_valid = or_valid_q;
    assign result    = or_result_q;
    assign zero      = or_zero_q;
    assign tag_out   = or_tag_q;

endmodule
